uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
// - Round-robin scheduler that shares one UART transmitter between N_REQ byte requesters.
// - Picks a requester, latches its byte and pulses tx_start into the TX datapath/FSM.
// - Tracks the frame through tx_busy and enforces a minimum idle gap between frames.
// - Flags a transmitter that never goes busy.
// - Sits between the client logic and the transmitter; it is the only driver of tx_start.
// PARAMETERS
// N_REQ         4   number of requesters, >=2
// DATA_W        8   byte width per requester
// GAP_CYCLES    2   idle clk cycles forced after tx_busy falls, 0 = no gap
// BUSY_TIMEOUT  16  max cycles WAIT_BUSY waits for tx_busy=1 before err_timeout, >=4
// PORTS
// clk          in   1              single clock, all logic on posedge
// reset        in   1              synchronous, active-high
// arb_enable   in   1              1 = new grants allowed
// req_valid    in   N_REQ          requester i has a byte; held until its req_ack
// req_data     in   N_REQ*DATA_W   byte i at [i*DATA_W +: DATA_W]
// req_ack      out  N_REQ          one-hot, 1-cycle pulse: byte of requester i consumed
// tx_busy      in   1              from transmitter, high while frame on the line
// tx_start     out  1              1-cycle start pulse to transmitter
// tx_data      out  DATA_W         byte to transmitter, stable from tx_start until next grant
// grant_id     out  clog2(N_REQ)   index of current/last granted requester
// sched_busy   out  1              1 whenever state != IDLE
// err_timeout  out  1              1-cycle pulse: tx_busy never rose after tx_start
// frame_cnt    out  16             completed frames, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (synchronous, active-high) values:
//   - state=IDLE, rr_ptr=0; all outputs 0: req_ack, tx_start, tx_data, grant_id,
//     sched_busy, err_timeout, frame_cnt.
// - Reset mid-frame: abandon immediately. No ack/start pending after reset, even if tx_busy=1.
// - All outputs are registered.
// - States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
// - IDLE:
//   - If arb_enable=1 and |req_valid: winner = first valid index scanning rr_ptr, rr_ptr+1, ...
//     modulo N_REQ.
//   - Latch tx_data<=req_data[winner] and grant_id<=winner; go to START.
//   - If arb_enable=0, req_valid is ignored.
// - START (exactly 1 cycle):
//   - tx_start=1 and req_ack[grant_id]=1 in the same cycle.
//   - rr_ptr <= (grant_id+1) mod N_REQ; N_REQ-1 wraps to 0.
//   - Go to WAIT_BUSY.
// - WAIT_BUSY:
//   - tx_busy=1 -> WAIT_DONE.
//   - Otherwise the timeout counter increments. On the BUSY_TIMEOUT-th cycle in WAIT_BUSY
//     (tx_busy still 0): err_timeout=1 for that cycle, go to GAP; frame_cnt is not incremented.
//   - The timeout counter clears on every entry to WAIT_BUSY.
// - WAIT_DONE:
//   - tx_busy=0 -> frame_cnt+1; go to GAP, or to IDLE if GAP_CYCLES=0.
// - GAP:
//   - Stay exactly GAP_CYCLES cycles, then IDLE.
//   - tx_busy is ignored.
// - Latency: req_valid seen in IDLE -> tx_start 1 cycle later, in START.
// - Back-to-back: minimum 2+GAP_CYCLES cycles from tx_busy fall to the next tx_start.
// - Requester contract:
//   - Drop req_valid, or present the next byte, on the edge after req_ack.
//   - The scheduler samples req_valid only in IDLE, so a held valid is never double-consumed.
// - arb_enable falling mid-frame does not abort; the frame completes, then the block holds IDLE.
// - Exactly one req_ack bit per grant; req_ack=0 in every state but START.
// - tx_data and grant_id hold their last values outside IDLE->START.
// TESTING
// - Single requester: reset, req_valid=0001, data0=0x5A; tx model raises busy 2 cycles after
//   start, drops 11 cycles later.
//   -> 1 tx_start, tx_data=0x5A, req_ack=0001 in same cycle.
//   -> frame_cnt=1; IDLE re-entered 2 cycles after busy fall.
// - Fairness/wrap: all 4 valid continuously, data i=0x10+i.
//   -> grant order 0,1,2,3,0,1; req_ack one-hot each START.
//   -> tx_data sequence 0x10,0x11,0x12,0x13,0x10.
// - Skip: valid=1010 with rr_ptr=2 -> grant 3, then 1.
// - Timeout: tx_busy tied 0, valid=0001.
//   -> err_timeout pulse 16 cycles after START; frame_cnt stays 0.
//   -> after GAP, next tx_start for a retried request.
// - Enable gating: arb_enable=0 with valid=1111 for 50 cycles -> no tx_start, sched_busy=0.
//   Drop enable during WAIT_DONE -> frame completes, frame_cnt+1, no further grant.
// - Reset mid-frame: assert reset in WAIT_DONE with tx_busy=1.
//   -> next cycle state IDLE, all outputs 0, rr_ptr=0.
//   -> first grant after release goes to lowest valid index.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the byte requesters, the TX scheduler and the UART transmitter.
// The scheduler takes the slave view; clients and transmitter together form the master side.
interface uart_tx_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ack;
  logic                    tx_busy;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ack, tx_start, tx_data
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ack, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte requesters,
// with busy tracking, a post-frame idle gap and a start-without-busy timeout.
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arb_enable,
  uart_tx_sched_if.slave           bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     sched_busy,
  output logic                     err_timeout,
  output logic [15:0]              frame_cnt
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t        state, next_state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic          found;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;

  // Round-robin pick: first valid index scanning upward from rr_ptr with wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // err_timeout is raised during the final WAIT_BUSY cycle and itself forces the exit,
  // so the pulse and the GAP transition always agree.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (arb_enable && found) next_state = START;
      START:     next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (err_timeout)      next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
        else if (bus.tx_busy) next_state = WAIT_DONE;
      end
      WAIT_DONE: if (!bus.tx_busy) next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt == GW'(GAP_CYCLES - 1)) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.req_ack  <= '0;
      sched_busy   <= 1'b0;
      err_timeout  <= 1'b0;
      frame_cnt    <= '0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      bus.tx_start <= (next_state == START);
      bus.req_ack  <= '0;
      sched_busy   <= (next_state != IDLE);
      err_timeout  <= (state == WAIT_BUSY) && !bus.tx_busy &&
                      (tmo_cnt == TW'(BUSY_TIMEOUT - 2));
      tmo_cnt      <= (state == WAIT_BUSY) ? tmo_cnt + 1'b1 : '0;
      gap_cnt      <= (state == GAP) ? gap_cnt + 1'b1 : '0;

      if (state == IDLE && next_state == START) begin
        grant_id    <= winner;
        bus.tx_data <= bus.req_data[winner*DATA_W +: DATA_W];
        bus.req_ack <= N_REQ'(1) << winner;
      end

      if (state == START)
        rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

      if (state == WAIT_DONE && !bus.tx_busy)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a cycle-stepped transmitter model plus event logs
// of every tx_start / err_timeout, checked against hand-computed expectations.
module tb_uart_tx_sched;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arb_enable = 1'b0;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        err_timeout;
  logic [15:0] frame_cnt;

  uart_tx_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_sched #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .GAP_CYCLES(2), .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable), .bus(bus),
    .grant_id(grant_id), .sched_busy(sched_busy),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_t     = -1;
  bit model_en = 1'b1, force_busy = 1'b0, drop_on_ack = 1'b0, saw_sched_busy = 1'b0;
  int n_start = 0, n_err = 0;
  int gq[$], dq[$], aq[$], sq[$], eq[$];
  int s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, log events, then advance the TX model
  // (busy rises 2 cycles after tx_start and stays high 11 cycles).
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.tx_start === 1'b1) begin
      n_start++;
      gq.push_back(int'(grant_id));
      dq.push_back(int'(bus.tx_data));
      aq.push_back(int'(bus.req_ack));
      sq.push_back(cyc);
    end
    if (err_timeout === 1'b1) begin
      n_err++;
      eq.push_back(cyc);
    end
    if (sched_busy === 1'b1) saw_sched_busy = 1'b1;
    if (drop_on_ack) bus.req_valid = bus.req_valid & ~bus.req_ack;
    if (!model_en) begin
      m_t = -1;
      bus.tx_busy = force_busy;
    end else begin
      if (bus.tx_start === 1'b1) m_t = 0;
      else if (m_t >= 0)         m_t++;
      bus.tx_busy = (m_t >= 2 && m_t < 13);
      if (m_t >= 13) m_t = -1;
    end
  endtask

  task automatic clear_log();
    n_start = 0;
    n_err   = 0;
    gq.delete(); dq.delete(); aq.delete(); sq.delete(); eq.delete();
    saw_sched_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    model_en = 1'b1; force_busy = 1'b0; drop_on_ack = 1'b0; arb_enable = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic run_until_starts(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_start < target && k < budget) begin
      step();
      k++;
    end
    check({tag, "_starts"}, n_start, target);
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (bus.tx_busy !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    check({tag, "_busy_seen"}, bus.tx_busy, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"},    bus.tx_start, 0);
    check({tag, "_req_ack"},     bus.req_ack, 0);
    check({tag, "_tx_data"},     bus.tx_data, 0);
    check({tag, "_grant_id"},    grant_id, 0);
    check({tag, "_sched_busy"},  sched_busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_frame_cnt"},   frame_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.tx_busy   = 1'b0;

    // Reset values
    repeat (3) step();
    check_all_zero("rst");
    reset = 1'b0;
    clear_log();

    // Single requester, byte 0x5A
    bus.req_data[7:0] = 8'h5A;
    drop_on_ack = 1'b1;
    arb_enable  = 1'b1;
    bus.req_valid = 4'b0001;
    step();
    check("t1_latency", bus.tx_start, 1);
    s = cyc;
    check("t1_ack",   bus.req_ack, 4'b0001);
    check("t1_data",  bus.tx_data, 8'h5A);
    check("t1_grant", grant_id, 0);
    repeat (14) step();
    check("t1_frame_cnt", frame_cnt, 1);
    step();
    check("t1_gap_busy", sched_busy, 1);
    step();
    check("t1_idle_after_gap", sched_busy, 0);
    repeat (10) step();
    check("t1_single_start", n_start, 1);
    bus.req_data[7:0] = 8'h10;

    // Fairness and wrap with all four requesters held valid
    do_reset();
    bus.req_valid = 4'b1111;
    run_until_starts(6, 200, "t2");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_grant%0d", i), gq[i], i % 4);
      check($sformatf("t2_ack%0d", i),   aq[i], 1 << (i % 4));
      check($sformatf("t2_data%0d", i),  dq[i], 8'h10 + (i % 4));
    end
    check("t2_spacing", sq[1] - sq[0], 17);

    // Skip: rr_ptr=2 after granting 1, then valid=1010 -> 3, then 1
    do_reset();
    drop_on_ack = 1'b1;
    bus.req_valid = 4'b0010;
    run_until_starts(1, 10, "t3_first");
    bus.req_valid = 4'b1010;
    run_until_starts(3, 100, "t3");
    check("t3_grant0", gq[0], 1);
    check("t3_grant1", gq[1], 3);
    check("t3_grant2", gq[2], 1);
    check("t3_data1",  dq[1], 8'h13);

    // Timeout: transmitter never goes busy, request held for retry
    do_reset();
    model_en = 1'b0;
    force_busy = 1'b0;
    bus.req_valid = 4'b0001;
    run_until_starts(1, 10, "t4_first");
    s = sq[0];
    run_until_starts(2, 40, "t4_retry");
    check("t4_err_pulses", n_err, 1);
    check("t4_err_delay",  eq[0] - s, 16);
    check("t4_retry_delay", sq[1] - s, 20);
    check("t4_frame_cnt",  frame_cnt, 0);

    // Enable gating
    do_reset();
    arb_enable = 1'b0;
    bus.req_valid = 4'b1111;
    repeat (50) step();
    check("t5_no_start",  n_start, 0);
    check("t5_never_busy", saw_sched_busy, 0);
    arb_enable = 1'b1;
    run_until_starts(1, 5, "t5");
    wait_busy("t5");
    step();
    arb_enable = 1'b0;
    repeat (40) step();
    check("t5_one_start", n_start, 1);
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_idle",      sched_busy, 0);

    // Reset mid-frame
    do_reset();
    bus.req_valid = 4'b0100;
    run_until_starts(1, 5, "t6");
    check("t6_grant", gq[0], 2);
    wait_busy("t6");
    step();
    check("t6_midframe", sched_busy, 1);
    model_en = 1'b0;
    force_busy = 1'b1;
    reset = 1'b1;
    step();
    check_all_zero("t6_rst");
    reset = 1'b0;
    force_busy = 1'b0;
    model_en = 1'b1;
    clear_log();
    bus.req_valid = 4'b1010;
    run_until_starts(1, 5, "t6_after");
    check("t6_after_grant", gq[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
